// File: rtl/video_timing_gen.sv
// Parametrised video timing generator: pixel clock-enable divider, sync/blank timing,
// pixel coordinates, line/frame strobes and four selectable test patterns.
module video_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 11,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 31,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   PIX_DIV   = 4,
  parameter int   CNTR_W    = 12
) (
  input  logic              vo_clk,
  input  logic              vo_reset,
  input  logic [1:0]        pattern_sel,
  input  logic [23:0]       fg_color,
  output logic              pix_ce,
  output logic [CNTR_W-1:0] pix_x,
  output logic [CNTR_W-1:0] pix_y,
  output logic              line_start,
  output logic              frame_start,
  output logic              vo_hsync,
  output logic              vo_vsync,
  output logic              vo_blank_,
  output logic [7:0]        vo_r,
  output logic [7:0]        vo_g,
  output logic [7:0]        vo_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int BAR_W   = CNTR_W + 3;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNTR_W-1:0] H_ACT_C  = CNTR_W'(H_ACTIVE);
  localparam logic [CNTR_W-1:0] H_SYNC_S = CNTR_W'(H_ACTIVE + H_FP);
  localparam logic [CNTR_W-1:0] H_SYNC_E = CNTR_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNTR_W-1:0] H_LAST   = CNTR_W'(H_TOTAL - 1);
  localparam logic [CNTR_W-1:0] V_ACT_C  = CNTR_W'(V_ACTIVE);
  localparam logic [CNTR_W-1:0] V_SYNC_S = CNTR_W'(V_ACTIVE + V_FP);
  localparam logic [CNTR_W-1:0] V_SYNC_E = CNTR_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNTR_W-1:0] V_LAST   = CNTR_W'(V_TOTAL - 1);
  localparam logic [BAR_W-1:0]  BAR_DIV  = BAR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    PAT_GRAD  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNTR_W-1:0] col_q, col_d, line_q, line_d;
  pattern_e          pat_q, pat_d;
  logic              ce_s, col_wrap_s, first_s, active_s, hs_act_s, vs_act_s;
  logic [BAR_W-1:0]  bar_s;
  logic [2:0]        bar_rgb_s;
  logic [23:0]       rgb_s;

  logic [CNTR_W-1:0] pix_x_q, pix_y_q;
  logic              line_start_q, frame_start_q, hsync_q, vsync_q, blank_n_q;
  logic [23:0]       rgb_q;

  // Next-state counters and the pixel value for the current (col, line)
  always_comb begin
    ce_s       = ~vo_reset & (div_q == DIV_W'(0));
    col_wrap_s = (col_q == H_LAST);
    first_s    = (col_q == CNTR_W'(0)) && (line_q == CNTR_W'(0));
    active_s   = (col_q < H_ACT_C) && (line_q < V_ACT_C);
    hs_act_s   = (col_q >= H_SYNC_S) && (col_q < H_SYNC_E);
    vs_act_s   = (line_q >= V_SYNC_S) && (line_q < V_SYNC_E);
    div_d      = (div_q == DIV_LAST) ? DIV_W'(0) : div_q + DIV_W'(1);

    if (col_wrap_s) begin
      col_d = CNTR_W'(0);
      if (line_q == V_LAST) begin
        line_d = CNTR_W'(0);
      end else begin
        line_d = line_q + CNTR_W'(1);
      end
    end else begin
      col_d  = col_q + CNTR_W'(1);
      line_d = line_q;
    end

    // The new selection already applies to pixel (0,0) of the frame that latches it
    if (first_s) begin
      pat_d = pattern_e'(pattern_sel);
    end else begin
      pat_d = pat_q;
    end

    bar_s = {col_q, 3'b000} / BAR_DIV;
    case (bar_s)
      BAR_W'(0): bar_rgb_s = 3'b111;
      BAR_W'(1): bar_rgb_s = 3'b110;
      BAR_W'(2): bar_rgb_s = 3'b011;
      BAR_W'(3): bar_rgb_s = 3'b010;
      BAR_W'(4): bar_rgb_s = 3'b101;
      BAR_W'(5): bar_rgb_s = 3'b100;
      BAR_W'(6): bar_rgb_s = 3'b001;
      default:   bar_rgb_s = 3'b000;
    endcase

    rgb_s = 24'h000000;
    if (active_s) begin
      case (pat_d)
        PAT_GRAD:  rgb_s = {8'hFF, line_q[4:0], 3'b000, col_q[4:0], 3'b000};
        PAT_BARS:  rgb_s = {{8{bar_rgb_s[2]}}, {8{bar_rgb_s[1]}}, {8{bar_rgb_s[0]}}};
        PAT_CHECK: rgb_s = (col_q[3] ^ line_q[3]) ? 24'hFFFFFF : 24'h000000;
        PAT_SOLID: rgb_s = fg_color;
        default:   rgb_s = 24'h000000;
      endcase
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // Divider, counters and the output register stage
  always_ff @(posedge vo_clk) begin
    if (vo_reset) begin
      div_q         <= DIV_W'(0);
      col_q         <= CNTR_W'(0);
      line_q        <= CNTR_W'(0);
      pat_q         <= PAT_GRAD;
      pix_x_q       <= CNTR_W'(0);
      pix_y_q       <= CNTR_W'(0);
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      blank_n_q     <= 1'b0;
      rgb_q         <= 24'h000000;
    end else begin
      div_q <= div_d;
      if (ce_s) begin
        col_q         <= col_d;
        line_q        <= line_d;
        pat_q         <= pat_d;
        pix_x_q       <= col_q;
        pix_y_q       <= line_q;
        line_start_q  <= (col_q == CNTR_W'(0));
        frame_start_q <= first_s;
        hsync_q       <= hs_act_s ? HSYNC_POL : ~HSYNC_POL;
        vsync_q       <= vs_act_s ? VSYNC_POL : ~VSYNC_POL;
        blank_n_q     <= active_s;
        rgb_q         <= rgb_s;
      end else begin
        line_start_q  <= 1'b0;
        frame_start_q <= 1'b0;
      end
    end
  end

  assign pix_ce      = ce_s;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vo_hsync    = hsync_q;
  assign vo_vsync    = vsync_q;
  assign vo_blank_   = blank_n_q;
  assign vo_r        = rgb_q[23:16];
  assign vo_g        = rgb_q[15:8];
  assign vo_b        = rgb_q[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a 640-wide mode (short frame, PIX_DIV=4) and a tiny PIX_DIV=1 mode,
// with per-pixel predictions checked by monitors plus directed hand-computed spot checks.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        rst_a, rst_b;
  logic [1:0]  sel_a, sel_b;
  logic [23:0] fg_a, fg_b;
  logic        ce_a, ls_a, fs_a, hs_a, vs_a, bl_a;
  logic        ce_b, ls_b, fs_b, hs_b, vs_b, bl_b;
  logic [11:0] x_a, y_a, x_b, y_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [52:0] out_a, out_b;

  assign out_a = {x_a, y_a, ls_a, fs_a, hs_a, vs_a, bl_a, r_a, g_a, b_a};
  assign out_b = {x_b, y_b, ls_b, fs_b, hs_b, vs_b, bl_b, r_b, g_b, b_b};

  video_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_a (
    .vo_clk(clk), .vo_reset(rst_a), .pattern_sel(sel_a), .fg_color(fg_a),
    .pix_ce(ce_a), .pix_x(x_a), .pix_y(y_a), .line_start(ls_a), .frame_start(fs_a),
    .vo_hsync(hs_a), .vo_vsync(vs_a), .vo_blank_(bl_a), .vo_r(r_a), .vo_g(g_a), .vo_b(b_a));

  video_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .HSYNC_POL(1'b1), .PIX_DIV(1)) dut_b (
    .vo_clk(clk), .vo_reset(rst_b), .pattern_sel(sel_b), .fg_color(fg_b),
    .pix_ce(ce_b), .pix_x(x_b), .pix_y(y_b), .line_start(ls_b), .frame_start(fs_b),
    .vo_hsync(hs_b), .vo_vsync(vs_b), .vo_blank_(bl_b), .vo_r(r_b), .vo_g(g_b), .vo_b(b_b));

  localparam logic [52:0] RST_A = {12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
  localparam logic [52:0] RST_B = {12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};

  logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected output record {x, y, line_start, frame_start, hsync, vsync, blank_, rgb}
  function automatic logic [52:0] model(input int x, input int y, input int p, input logic [23:0] fg,
                                        input int ha, input int hf, input int hs,
                                        input int va, input int vf, input int vs,
                                        input logic hp, input logic vp);
    logic act, hsa, vsa;
    logic [23:0] rgb;
    act = (x < ha) && (y < va);
    hsa = (x >= ha + hf) && (x < ha + hf + hs);
    vsa = (y >= va + vf) && (y < va + vf + vs);
    rgb = 24'h000000;
    if (act) begin
      case (p)
        0:       rgb = {8'hFF, 8'((y % 32) * 8), 8'((x % 32) * 8)};
        1:       rgb = bars[(x * 8) / ha];
        2:       rgb = (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
        default: rgb = fg;
      endcase
    end
    return {12'(x), 12'(y), (x == 0), (x == 0 && y == 0), hsa ? hp : ~hp, vsa ? vp : ~vp, act, rgb};
  endfunction

  // Predictors: push the expected record for every pixel slot issued
  logic [52:0] qa[$];
  logic [52:0] qb[$];
  int a_col = 0, a_line = 0, a_div = 0, a_pat = 0;
  int b_col = 0, b_line = 0, b_pat = 0;

  initial forever begin
    @(negedge clk); #1;
    if (rst_a) begin
      a_col = 0; a_line = 0; a_div = 0; a_pat = 0;
    end else begin
      if (a_div == 0) begin
        if (a_col == 0 && a_line == 0) a_pat = int'(sel_a);
        qa.push_back(model(a_col, a_line, a_pat, fg_a, 640, 16, 96, 4, 1, 2, 1'b0, 1'b0));
        if (a_col == 799) begin
          a_col = 0;
          a_line = (a_line == 7) ? 0 : a_line + 1;
        end else a_col++;
      end
      a_div = (a_div == 3) ? 0 : a_div + 1;
    end
  end

  initial forever begin
    @(negedge clk); #1;
    if (rst_b) begin
      b_col = 0; b_line = 0; b_pat = 0;
    end else begin
      if (b_col == 0 && b_line == 0) b_pat = int'(sel_b);
      qb.push_back(model(b_col, b_line, b_pat, fg_b, 8, 1, 2, 4, 1, 1, 1'b1, 1'b0));
      if (b_col == 11) begin
        b_col = 0;
        b_line = (b_line == 6) ? 0 : b_line + 1;
      end else b_col++;
    end
  end

  // Monitors: pop and compare whenever the DUT flagged a pixel clock enable
  logic m_ce_a, m_rs_a, m_ce_b, m_rs_b;
  logic [52:0] last_a, last_b, e_a, e_b;

  initial forever begin
    @(negedge clk); #2;
    m_ce_a = ce_a; m_rs_a = rst_a;
    @(posedge clk); #1;
    if (m_rs_a) begin
      last_a = RST_A;
      chk("a_reset_state", out_a, RST_A);
    end else if (m_ce_a) begin
      if (qa.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_scoreboard: pix_ce with no expected pixel at %0t", $time);
      end else begin
        e_a = qa.pop_front();
        last_a = e_a;
        chk("a_pixel", out_a, e_a);
      end
    end else begin
      chk("a_hold", out_a, {last_a[52:29], 2'b00, last_a[26:0]});
    end
  end

  initial forever begin
    @(negedge clk); #2;
    m_ce_b = ce_b; m_rs_b = rst_b;
    @(posedge clk); #1;
    if (m_rs_b) begin
      last_b = RST_B;
      chk("b_reset_state", out_b, RST_B);
    end else if (m_ce_b) begin
      if (qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_scoreboard: pix_ce with no expected pixel at %0t", $time);
      end else begin
        e_b = qb.pop_front();
        last_b = e_b;
        chk("b_pixel", out_b, e_b);
      end
    end else begin
      chk("b_hold", out_b, {last_b[52:29], 2'b00, last_b[26:0]});
    end
  end

  // Cycles since reset release; slot k is visible at a_cyc = 4k+1 and b_cyc = k+1
  int a_cyc = 0, b_cyc = 0;
  initial forever begin
    @(posedge clk);
    if (rst_a) a_cyc = 0; else a_cyc++;
    if (rst_b) b_cyc = 0; else b_cyc++;
  end

  task automatic wait_a(input int c);
    while (a_cyc < c) begin @(posedge clk); #1; end
  endtask
  task automatic at_a(input int k);
    wait_a(4 * k + 1);
  endtask
  task automatic at_b(input int k);
    while (b_cyc < k + 1) begin @(posedge clk); #1; end
  endtask

  task automatic seq_a();
    rst_a = 1'b1; sel_a = 2'd1; fg_a = 24'h000000;
    repeat (4) @(posedge clk);
    #1 rst_a = 1'b0;
    wait_a(1);
    chk("a_first_fs", fs_a, 1'b1);
    chk("a_first_ls", ls_a, 1'b1);
    chk("a_bar0_white", {r_a, g_a, b_a}, 24'hFFFFFF);
    for (int c = 1; c <= 8; c++) begin
      wait_a(c);
      chk("a_pix_ce_period4", ce_a, (c % 4 == 0));
    end
    at_a(80);  chk("a_x80", x_a, 12'd80); chk("a_x80_yellow", {r_a, g_a, b_a}, 24'hFFFF00);
    at_a(639); chk("a_x639_black", {r_a, g_a, b_a}, 24'h000000); chk("a_x639_active", bl_a, 1'b1);
    at_a(640); chk("a_x640_blank", bl_a, 1'b0);
    at_a(655); chk("a_hs_655", hs_a, 1'b1);
    at_a(656); chk("a_hs_656", hs_a, 1'b0);
    at_a(751); chk("a_hs_751", hs_a, 1'b0);
    at_a(752); chk("a_hs_752", hs_a, 1'b1);
    at_a(800); chk("a_line1_xy", {x_a, y_a}, {12'd0, 12'd1});
    chk("a_line1_ls", ls_a, 1'b1); chk("a_line1_fs", fs_a, 1'b0);
    at_a(3200); chk("a_vs_line4", vs_a, 1'b1); chk("a_line4_blank", {bl_a, r_a, g_a, b_a}, 25'h0);
    at_a(4000); chk("a_vs_line5", vs_a, 1'b0);
    at_a(4800); chk("a_vs_line6", vs_a, 1'b0);
    at_a(5600); chk("a_vs_line7", vs_a, 1'b1);
    wait_a(25600); chk("a_fs_before", fs_a, 1'b0);
    wait_a(25601); chk("a_fs_interval", fs_a, 1'b1); chk("a_frame2_xy", {x_a, y_a}, 24'h0);
    wait_a(25602); chk("a_fs_width", fs_a, 1'b0);
  endtask

  task automatic seq_b();
    rst_b = 1'b1; sel_b = 2'd0; fg_b = 24'h123456;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    at_b(0);
    chk("b_first_xy", {x_b, y_b}, 24'h0);
    chk("b_first_fs_ls", {fs_b, ls_b}, 2'b11);
    chk("b_grad_00", {r_b, g_b, b_b}, 24'hFF0000);
    for (int k = 1; k <= 11; k++) begin
      at_b(k);
      chk("b_pix_ce_const", ce_b, 1'b1);
      chk("b_fs_low", fs_b, 1'b0);
      chk("b_hsync", hs_b, (k == 9 || k == 10));
      chk("b_blank_x", bl_b, (k < 8));
    end
    at_b(27); chk("b_xy_3_2", {x_b, y_b}, {12'd3, 12'd2}); chk("b_grad_3_2", {r_b, g_b, b_b}, 24'hFF1018);
    at_b(43); chk("b_blank_7_3", bl_b, 1'b1);
    at_b(44); chk("b_blank_8_3", {bl_b, r_b, g_b, b_b}, 25'h0);
    at_b(48); chk("b_blank_0_4", bl_b, 1'b0); chk("b_vs_line4", vs_b, 1'b1);
    at_b(60); chk("b_vs_line5", vs_b, 1'b0);
    at_b(72); chk("b_vs_line6", vs_b, 1'b1);
    sel_b = 2'd2;
    at_b(84); chk("b_frame1_fs_ls", {fs_b, ls_b}, 2'b11); chk("b_check_00", {r_b, g_b, b_b}, 24'h000000);
    at_b(85); chk("b_fs_one_cycle", {fs_b, ls_b}, 2'b00);
    at_b(96); chk("b_ls_only", {fs_b, ls_b}, 2'b01);
    sel_b = 2'd3;
    at_b(110); chk("b_check_midframe", {r_b, g_b, b_b}, 24'h000000);
    at_b(168); chk("b_frame2_fs", fs_b, 1'b1); chk("b_solid_00", {r_b, g_b, b_b}, 24'h123456);
    at_b(177); chk("b_solid_blanked", {r_b, g_b, b_b}, 24'h000000); chk("b_hs_x9", hs_b, 1'b1);
    at_b(209); chk("b_solid_5_3", {r_b, g_b, b_b}, 24'h123456);
    rst_b = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("b_rst_pix_ce", ce_b, 1'b0);
      chk("b_rst_syncs", {hs_b, vs_b}, 2'b01);
      chk("b_rst_xy_fs", {x_b, y_b, fs_b, bl_b}, 26'h0);
    end
    rst_b = 1'b0;
    at_b(0);
    chk("b_post_rst_xy", {x_b, y_b}, 24'h0);
    chk("b_post_rst_fs", fs_b, 1'b1);
    chk("b_post_rst_solid", {r_b, g_b, b_b}, 24'h123456);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      seq_a();
      seq_b();
    join
    @(posedge clk); #2;
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
